// File: rtl/reorder_buffer_pkg.sv
// Shared constants and types for the reorder buffer: RV32 opcodes,
// ROB id width/count, null id, query result bundle and small helpers.
package reorder_buffer_pkg;

    localparam int ROB_ID_W       = 5;
    localparam int ROB_SIZE       = 31;
    localparam int ROB_FULL_LEVEL = 29;

    typedef logic [ROB_ID_W-1:0] rob_id_t;

    localparam rob_id_t ROB_NULL_ID = '0;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef struct packed {
        rob_id_t     dep;
        logic [31:0] value;
    } query_t;

    // Ids run 1..31; id 0 is reserved as "no producer".
    function automatic rob_id_t rob_next(input rob_id_t id);
        return (id == rob_id_t'(ROB_SIZE)) ? rob_id_t'(1) : id + rob_id_t'(1);
    endfunction

    // Stores and branches carry no destination register.
    function automatic logic writes_rd(input logic [6:0] op,
                                       input logic [4:0] rd);
        return (rd != 5'd0) && (op != OP_STORE) && (op != OP_BRANCH);
    endfunction

endpackage

// File: rtl/rob_reg_status.sv
// Register rename table (reg -> producing ROB id) plus architectural regfile.
// Ports: two raw query ports, one rename write, one commit write, flush.
module rob_reg_status
    import reorder_buffer_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush,
    input  logic [4:0]  query_reg_1,
    input  logic [4:0]  query_reg_2,
    output rob_id_t     query_tag_1,
    output rob_id_t     query_tag_2,
    output logic [31:0] query_val_1,
    output logic [31:0] query_val_2,
    input  logic        rename_en,
    input  logic [4:0]  rename_reg,
    input  rob_id_t     rename_id,
    input  logic        commit_en,
    input  logic [4:0]  commit_reg,
    input  rob_id_t     commit_id,
    input  logic [31:0] commit_value
);

    rob_id_t     tag_tbl [32];
    logic [31:0] regfile [32];

    // Entry 0 is never written, so x0 reads as tag 0 / value 0.
    assign query_tag_1 = tag_tbl[query_reg_1];
    assign query_tag_2 = tag_tbl[query_reg_2];
    assign query_val_1 = regfile[query_reg_1];
    assign query_val_2 = regfile[query_reg_2];

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < 32; i++) begin
                tag_tbl[i] <= ROB_NULL_ID;
                regfile[i] <= '0;
            end
        end else if (rdy_in) begin
            if (commit_en && commit_reg != 5'd0) begin
                regfile[commit_reg] <= commit_value;
            end
            if (flush) begin
                for (int i = 0; i < 32; i++) begin
                    tag_tbl[i] <= ROB_NULL_ID;
                end
            end else begin
                // Only release the mapping if no younger writer took it.
                if (commit_en && commit_reg != 5'd0
                    && tag_tbl[commit_reg] == commit_id) begin
                    tag_tbl[commit_reg] <= ROB_NULL_ID;
                end
                // A same-cycle rename overrides the release above.
                if (rename_en && rename_reg != 5'd0) begin
                    tag_tbl[rename_reg] <= rename_id;
                end
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// 31-entry in-order reorder buffer: issue, CDB writeback, in-order commit,
// branch mispredict flush, operand query. Ports: issue bundle, full/tail id,
// two query ports, CDB, commit id, clear/new_pc. Optional ROB_CDB_BYPASS_EN
// lets queries see a same-cycle CDB result.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        _issue_ready,
    input  logic [6:0]  _issue_type,
    input  logic [4:0]  _issue_rd,
    input  logic [31:0] _issue_value,
    input  logic [31:0] _issue_inst_addr,
    input  logic [31:0] _issue_jump_imm,
    output logic        _rob_full,
    output logic [4:0]  _rob_tail_id,
    input  logic [4:0]  _query_reg_1,
    input  logic [4:0]  _query_reg_2,
    output logic [4:0]  _query_dep_1,
    output logic [4:0]  _query_dep_2,
    output logic [31:0] _query_value_1,
    output logic [31:0] _query_value_2,
    input  logic        _cdb_valid,
    input  logic [4:0]  _cdb_rob_id,
    input  logic [31:0] _cdb_value,
    output logic        _commit_valid,
    output logic [4:0]  _commit_rob_id,
    output logic        _clear,
    output logic [31:0] _new_pc
);

    rob_id_t     head;
    rob_id_t     tail;
    logic [4:0]  count;
    logic [31:0] busy;
    logic [31:0] ready;
    logic [6:0]  e_type  [32];
    logic [4:0]  e_rd    [32];
    logic [31:0] e_value [32];
    logic [31:0] e_addr  [32];
    logic [31:0] e_imm   [32];

    logic        commit_fire;
    logic        mispredict;
    logic        issue_fire;
    logic        born_ready;
    logic        cdb_hit;
    logic [31:0] issue_val;
    logic [31:0] redirect_pc;
    logic [4:0]  count_next;

    rob_id_t     tag_1;
    rob_id_t     tag_2;
    logic [31:0] rf_1;
    logic [31:0] rf_2;
    query_t      res_1;
    query_t      res_2;

    always_comb begin
        commit_fire = busy[head] & ready[head];
        // Branch: rd[0] holds the prediction, value[0] the outcome.
        mispredict  = commit_fire && (e_type[head] == OP_BRANCH)
                      && (e_value[head][0] != e_rd[head][0]);
        redirect_pc = e_value[head][0] ? e_addr[head] + e_imm[head]
                                       : e_addr[head] + 32'd4;
        issue_fire  = _issue_ready && !_clear && !mispredict
                      && (count != 5'(ROB_SIZE));
        born_ready  = _issue_type inside {OP_LUI, OP_JAL, OP_JALR};
        issue_val   = (_issue_type == OP_JAL)
                      ? _issue_inst_addr + _issue_jump_imm : _issue_value;
        cdb_hit     = _cdb_valid && busy[_cdb_rob_id];
        count_next  = count + 5'(issue_fire) - 5'(commit_fire);
    end

    assign _rob_full = (count >= 5'(ROB_FULL_LEVEL));

    rob_reg_status u_reg_status (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .flush        (mispredict),
        .query_reg_1  (_query_reg_1),
        .query_reg_2  (_query_reg_2),
        .query_tag_1  (tag_1),
        .query_tag_2  (tag_2),
        .query_val_1  (rf_1),
        .query_val_2  (rf_2),
        .rename_en    (issue_fire && writes_rd(_issue_type, _issue_rd)),
        .rename_reg   (_issue_rd),
        .rename_id    (tail),
        .commit_en    (commit_fire && writes_rd(e_type[head], e_rd[head])),
        .commit_reg   (e_rd[head]),
        .commit_id    (head),
        .commit_value (e_value[head])
    );

    function automatic query_t resolve(input rob_id_t     tag,
                                       input logic [31:0] rf,
                                       input logic        ent_ready,
                                       input logic [31:0] ent_value,
                                       input logic        cdb_v,
                                       input rob_id_t     cdb_id,
                                       input logic [31:0] cdb_val);
        query_t r;
        r.dep   = tag;
        r.value = rf;
        if (tag != ROB_NULL_ID) begin
            if (ent_ready) begin
                r.dep   = ROB_NULL_ID;
                r.value = ent_value;
            end
`ifdef ROB_CDB_BYPASS_EN
            else if (cdb_v && cdb_id == tag) begin
                r.dep   = ROB_NULL_ID;
                r.value = cdb_val;
            end
`else
            else if (cdb_v && cdb_id == tag && cdb_val[0]) begin
                r.dep   = tag;
            end
`endif
        end
        return r;
    endfunction

    always_comb begin
        res_1 = resolve(tag_1, rf_1, ready[tag_1], e_value[tag_1],
                        _cdb_valid, _cdb_rob_id, _cdb_value);
        res_2 = resolve(tag_2, rf_2, ready[tag_2], e_value[tag_2],
                        _cdb_valid, _cdb_rob_id, _cdb_value);
    end

    assign _query_dep_1   = res_1.dep;
    assign _query_value_1 = res_1.value;
    assign _query_dep_2   = res_2.dep;
    assign _query_value_2 = res_2.value;

    // Control state: pointers, occupancy, busy/ready flags, outputs.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            head          <= rob_id_t'(1);
            tail          <= rob_id_t'(1);
            count         <= '0;
            busy          <= '0;
            ready         <= '0;
            _rob_tail_id  <= ROB_NULL_ID;
            _commit_valid <= 1'b0;
            _commit_rob_id <= ROB_NULL_ID;
            _clear        <= 1'b0;
            _new_pc       <= '0;
        end else if (rdy_in) begin
            _commit_valid  <= commit_fire;
            _commit_rob_id <= commit_fire ? head : ROB_NULL_ID;
            _clear         <= mispredict;
            if (mispredict) begin
                _new_pc      <= redirect_pc;
                head         <= rob_id_t'(1);
                tail         <= rob_id_t'(1);
                count        <= '0;
                busy         <= '0;
                ready        <= '0;
                _rob_tail_id <= ROB_NULL_ID;
            end else begin
                if (cdb_hit) begin
                    ready[_cdb_rob_id] <= 1'b1;
                end
                if (commit_fire) begin
                    busy[head]  <= 1'b0;
                    ready[head] <= 1'b0;
                    head        <= rob_next(head);
                end
                if (issue_fire) begin
                    busy[tail]   <= 1'b1;
                    ready[tail]  <= born_ready;
                    tail         <= rob_next(tail);
                    _rob_tail_id <= tail;
                end
                count <= count_next;
            end
        end
    end

    // Entry payload; validity is tracked by busy, so no reset needed.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            if (issue_fire) begin
                e_type[tail]  <= _issue_type;
                e_rd[tail]    <= _issue_rd;
                e_value[tail] <= issue_val;
                e_addr[tail]  <= _issue_inst_addr;
                e_imm[tail]   <= _issue_jump_imm;
            end
            if (cdb_hit && !mispredict) begin
                e_value[_cdb_rob_id] <= _cdb_value;
            end
        end
    end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 clk_in  in  1  system clock; all state updates on rising edge.
REQ-002 rst_in  in  1  synchronous reset, active-low.
REQ-003 rdy_in  in  1  when low, all state holds and no output register updates.
REQ-004 _issue_ready  in  1  issue strobe; one entry allocated per cycle high.
REQ-005 _issue_type  in  7  RV32 opcode of issued instruction.
REQ-006 _issue_rd  in  5  destination register; for branches bit0 = predicted taken.
REQ-007 _issue_value  in  32  precomputed result (LUI imm, JALR link); entry is born ready for LUI.
REQ-008 _issue_inst_addr  in  32  instruction address.
REQ-009 _issue_jump_imm  in  32  branch offset (branches) or link step 2/4 (JAL).
REQ-010 _rob_full  out  1  high when occupancy >= 29 (covers two in-flight issue cycles).
REQ-011 _rob_tail_id  out  5  id of most recently allocated entry (ids 1..31; 0 = none).
REQ-012 _query_reg_1 / _query_reg_2  in  5 each  source registers to resolve (combinational).
REQ-013 _query_dep_1 / _query_dep_2  out  5 each  producing ROB id, 0 if value is final.
REQ-014 _query_value_1 / _query_value_2  out  32 each  value when dep is 0.
REQ-015 _cdb_valid, _cdb_rob_id[4:0], _cdb_value[31:0]  in  result broadcast; branches: value bit0 = actual taken.
REQ-016 _commit_valid, _commit_rob_id[4:0]  out  retiring entry (stores release in LSB).
REQ-017 _clear  out  1  one-cycle flush on branch mispredict; _new_pc out 32 = correct target.

Function
REQ-018 Circular queue of 31 entries, ids 1..31, wrap 31 -> 1; id 0 never allocated.
REQ-019 Entry fields: busy, ready, type, rd, value, inst_addr, jump_imm.
REQ-020 Issue: tail advances, entry written busy, ready = (type is LUI/JAL/JALR); reg_status[rd] <= new id unless rd = 0, store, or branch.
REQ-021 CDB: entry _cdb_rob_id gets value, ready = 1 next cycle; CDB for non-busy id ignored.
REQ-022 Commit: at most one per cycle, head entry when busy and ready; latency CDB -> commit >= 1 cycle.
REQ-023 Commit writes regfile[rd] (rd != 0, non-store, non-branch); clears reg_status[rd] only if it still equals head id.
REQ-024 Branch commit with actual != predicted: _clear = 1, _new_pc = actual ? addr + jump_imm : addr + 4; entire ROB and reg_status emptied next cycle.
REQ-025 Same-cycle issue, CDB, commit all legal; issue into a register committing that cycle keeps the new id.
REQ-026 Query: dep = reg_status[r] unless that entry is ready (then dep 0, value = entry value); x0 always dep 0, value 0.
REQ-027 Issue while _clear asserted is dropped; empty ROB asserts no _commit_valid.

Reset
REQ-028 rst_in low: head = tail = 1, count 0, all busy/ready 0, reg_status 0, regfile 0, _clear 0, _new_pc 0, _commit_valid 0, _rob_tail_id 0.
REQ-029 Reset mid-operation discards all entries; first post-reset issue gets id 1.

Configuration
REQ-030 ROB_CDB_BYPASS_EN defined: query returns same-cycle _cdb_value with dep 0 when dep id matches _cdb_rob_id; undefined: CDB visible to queries one cycle later.

Structure
REQ-031 Shared package: opcode constants, ROB id width (5), entry count (31), null id 0.
REQ-032 Sub-module rob_reg_status: 32-entry reg_status table plus regfile, two query ports, one rename and one commit write port.

Verification
REQ-033 Reset, issue ADDI x5 -> tail_id 1; query x5 -> dep 1; CDB id1 = 0x2A -> next cycle commit, x5 = 0x2A, dep 0.
REQ-034 Issue 29 entries without CDB -> _rob_full 1; commit one -> _rob_full 0; allocate through id 31 -> next id 1.
REQ-035 Branch at 0x100, predicted taken, imm 0x40, CDB bit0 = 0 -> commit asserts _clear, _new_pc 0x104, ROB empty.
REQ-036 Two writers to x7 (ids 3, 4); commit id 3 -> reg_status[x7] remains 4.
REQ-037 With bypass: CDB id 2 = 0x55 while querying its register -> dep 0, value 0x55 same cycle; without: dep 2.
REQ-038 rdy_in low for 3 cycles with pending CDB -> no state change; resumes exactly.
